// File: rtl/sl_tx_scheduler_if.sv
// Register-bus bundle between sl_tx_scheduler (master) and one SlTransmitter (slave).
// tx_d_out bit 16 carries the transmitter busy flag.
interface sl_tx_scheduler_if;
    logic [31:0] tx_d_in;
    logic        tx_addr;
    logic        tx_wr_en;
    logic [31:0] tx_d_out;

    modport master (
        output tx_d_in,
        output tx_addr,
        output tx_wr_en,
        input  tx_d_out
    );

    modport slave (
        input  tx_d_in,
        input  tx_addr,
        input  tx_wr_en,
        output tx_d_out
    );
endinterface

// File: rtl/sl_tx_scheduler.sv
// Round-robin scheduler sharing one SL transmitter among NUM_REQ requesters.
// Optional watchdog with transmitter abort in WAIT_DONE: define SL_SCHED_TIMEOUT_EN.
module sl_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int START_WAIT     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [32*NUM_REQ-1:0]  req_data_i,
    input  logic [6*NUM_REQ-1:0]   req_len_i,
    input  logic [3*NUM_REQ-1:0]   req_freq_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic [2:0]             grant_id_o,
    sl_tx_scheduler_if.master      tx
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_CFG, S_DATA, S_WAIT_START,
        S_WAIT_DONE, S_DONE, S_REJECT, S_ABORT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  win_q, win_d;
    logic [31:0] data_q, data_d;
    logic [5:0]  len_q, len_d;
    logic [2:0]  freq_q, freq_d;
    logic [15:0] cnt_q, cnt_d;
    logic        terr_q, terr_d;

    logic        arb_found;
    logic [2:0]  arb_idx;
    int          arb_j;
    logic [5:0]  arb_len;
    logic        arb_len_bad;
    logic        tx_busy;
    logic        unused_ok;

    assign tx_busy    = tx.tx_d_out[16];
    assign busy_o     = (state_q != S_IDLE);
    assign grant_id_o = win_q;

`ifdef SL_SCHED_TIMEOUT_EN
    assign unused_ok = ^{tx.tx_d_out[31:17], tx.tx_d_out[15:0]};
`else
    assign unused_ok = ^{tx.tx_d_out[31:17], tx.tx_d_out[15:0], 32'(TIMEOUT_CYCLES)};
`endif

    // Round-robin search: first pending requester at or after the pointer.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_j = int'(ptr_q) + i;
            if (arb_j >= NUM_REQ) arb_j = arb_j - NUM_REQ;
            if (!arb_found && req_i[arb_j]) begin
                arb_found = 1'b1;
                arb_idx   = 3'(arb_j);
            end
        end
    end

    assign arb_len     = req_len_i[6*int'(arb_idx) +: 6];
    assign arb_len_bad = arb_len[0] || (arb_len < 6'd8) || (arb_len > 6'd32);

    always_comb begin
        // NOTE: every signal written here is defaulted first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        data_d      = data_q;
        len_d       = len_q;
        freq_d      = freq_q;
        cnt_d       = cnt_q;
        terr_d      = terr_q;
        tx.tx_wr_en = 1'b0;
        tx.tx_addr  = 1'b0;
        tx.tx_d_in  = '0;
        ack_o       = '0;
        err_o       = 1'b0;

        unique case (state_q)
            S_IDLE: if (|req_i) state_d = S_ARB;
            S_ARB: begin
                // A request dropped before this cycle is simply not found.
                if (arb_found) begin
                    win_d   = arb_idx;
                    data_d  = req_data_i[32*int'(arb_idx) +: 32];
                    len_d   = arb_len;
                    freq_d  = req_freq_i[3*int'(arb_idx) +: 3];
                    state_d = arb_len_bad ? S_REJECT : S_CFG;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CFG: begin
                tx.tx_wr_en = 1'b1;
                tx.tx_addr  = 1'b1;
                tx.tx_d_in  = {22'b0, freq_q, 1'b0, len_q};
                state_d     = S_DATA;
            end
            S_DATA: begin
                tx.tx_wr_en = 1'b1;
                tx.tx_d_in  = (len_q == 6'd32) ? data_q
                                               : (data_q & ((32'd1 << len_q) - 32'd1));
                cnt_d       = '0;
                state_d     = S_WAIT_START;
            end
            S_WAIT_START: begin
                tx.tx_addr = 1'b1;
                if (tx_busy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == 16'(START_WAIT - 1)) begin
                    // The word may already have left the line before the first poll.
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_DONE: begin
                tx.tx_addr = 1'b1;
                if (!tx_busy) begin
                    state_d = S_DONE;
`ifdef SL_SCHED_TIMEOUT_EN
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
`ifdef SL_SCHED_TIMEOUT_EN
            S_ABORT: begin
                tx.tx_wr_en = 1'b1;
                tx.tx_addr  = 1'b1;
                tx.tx_d_in  = {22'b0, freq_q, 1'b0, 6'd0};
                terr_d      = 1'b1;
                state_d     = S_DONE;
            end
`endif
            S_DONE: begin
                ack_o   = NUM_REQ'(1) << win_q;
`ifdef SL_SCHED_TIMEOUT_EN
                err_o   = terr_q;
`endif
                terr_d  = 1'b0;
                ptr_d   = (int'(win_q) == NUM_REQ - 1) ? 3'd0 : win_q + 3'd1;
                state_d = S_IDLE;
            end
            S_REJECT: begin
                ack_o   = NUM_REQ'(1) << win_q;
                err_o   = 1'b1;
                ptr_d   = (int'(win_q) == NUM_REQ - 1) ? 3'd0 : win_q + 3'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            freq_q  <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            data_q  <= data_d;
            len_q   <= len_d;
            freq_q  <= freq_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

endmodule

// File: tb/tb_sl_tx_scheduler.sv
// Randomized bench for sl_tx_scheduler: transaction-level round-robin and timing model plus a
// behavioural transmitter stub whose busy window is set per transfer.
module tb_sl_tx_scheduler;
    localparam int N  = 4;
    localparam int SW = 8;
`ifdef SL_SCHED_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [32*N-1:0] req_data;
    logic [6*N-1:0] req_len;
    logic [3*N-1:0] req_freq;
    logic [N-1:0]   ack;
    logic           err;
    logic           busy;
    logic [2:0]     grant_id;

    sl_tx_scheduler_if tx ();

    sl_tx_scheduler #(.NUM_REQ(N), .START_WAIT(SW), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .req_data_i(req_data),
        .req_len_i (req_len),
        .req_freq_i(req_freq),
        .ack_o     (ack),
        .err_o     (err),
        .busy_o    (busy),
        .grant_id_o(grant_id),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stub: busy rises stub_delay cycles after the data write, lasts stub_len cycles.
    int     data_cyc = -100000;
    longint stub_delay = 1;
    longint stub_len = 1;
    logic   stub_busy;
    always @(posedge clk) if (tx.tx_wr_en && !tx.tx_addr) data_cyc <= cyc;
    assign stub_busy = (longint'(cyc) >= longint'(data_cyc) + stub_delay) &&
                       (longint'(cyc) <  longint'(data_cyc) + stub_delay + stub_len);
    assign tx.tx_d_out = {15'h2a5c, stub_busy, 16'hbeef};

    typedef struct {
        int          c;
        logic        a;
        logic [31:0] d;
    } wr_t;
    wr_t wr_q[$];
    always @(negedge clk) if (tx.tx_wr_en) wr_q.push_back('{cyc, tx.tx_addr, tx.tx_d_in});

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [31:0] f_data[N];
    logic [5:0]  f_len[N];
    logic [2:0]  f_freq[N];
    int          ptr_m = 0;

    task automatic pack_fields();
        for (int i = 0; i < N; i++) begin
            req_data[32*i +: 32] = f_data[i];
            req_len[6*i +: 6]    = f_len[i];
            req_freq[3*i +: 3]   = f_freq[i];
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_ack"}, 64'(ack), 0);
        check({pfx, "_err"}, 64'(err), 0);
        check({pfx, "_busy"}, 64'(busy), 0);
        check({pfx, "_grant"}, 64'(grant_id), 0);
        check({pfx, "_wr_en"}, 64'(tx.tx_wr_en), 0);
        check({pfx, "_addr"}, 64'(tx.tx_addr), 0);
        check({pfx, "_d_in"}, 64'(tx.tx_d_in), 0);
    endtask

    task automatic hard_reset();
        req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        wr_q.delete();
        @(negedge clk);
    endtask

    // Called at a negedge while the DUT is idle; raises every requester in 'set' and
    // follows each to its ack, dropping req as soon as the ack is seen.
    task automatic run_burst(input logic [N-1:0] set);
        logic [N-1:0] pend;
        int  c0, winner, exp_ack, first_low, wd_start, budget;
        bit  legal, exp_err, abort, got_ack;
        logic prev_addr;
        wr_t exp_w[$];

        pack_fields();
        req  = set;
        pend = set;
        c0   = cyc;
        while (pend != 0) begin
            winner = -1;
            for (int k = 0; k < N; k++)
                if (winner < 0 && pend[(ptr_m + k) % N]) winner = (ptr_m + k) % N;
            legal = (f_len[winner] % 2 == 0) && (f_len[winner] >= 8) && (f_len[winner] <= 32);
            abort = 1'b0;
            exp_w.delete();
            if (!legal) begin
                exp_ack = c0 + 2;
                exp_err = 1'b1;
            end else begin
                exp_w.push_back('{c0 + 2, 1'b1, {22'b0, f_freq[winner], 1'b0, f_len[winner]}});
                exp_w.push_back('{c0 + 3, 1'b0, (f_len[winner] == 32) ? f_data[winner]
                                  : 32'(64'(f_data[winner]) % (64'd1 << f_len[winner]))});
                exp_err = 1'b0;
                if (stub_delay > SW) begin
                    exp_ack = c0 + 4 + SW;
                end else begin
                    wd_start  = c0 + 4 + int'(stub_delay);
                    first_low = c0 + 3 + int'(stub_delay + stub_len);
                    if (first_low < wd_start) first_low = wd_start;
`ifdef SL_SCHED_TIMEOUT_EN
                    abort = (first_low - wd_start >= TO);
`endif
                    if (abort) begin
                        exp_ack = wd_start + TO + 1;
                        exp_err = 1'b1;
                        exp_w.push_back('{exp_ack - 1, 1'b1, {22'b0, f_freq[winner], 7'b0}});
                    end else begin
                        exp_ack = first_low + 1;
                    end
                end
            end

            got_ack   = 1'b0;
            prev_addr = tx.tx_addr;
            budget    = exp_ack - cyc + 20;
            for (int t = 0; t < budget && !got_ack; t++) begin
                @(negedge clk);
                if (ack != 0) got_ack = 1'b1;
                else prev_addr = tx.tx_addr;
            end
            if (!got_ack) begin
                check("ack_timeout", 0, 1);
                hard_reset();
                return;
            end
            check("ack_vec", 64'(ack), 64'(1) << winner);
            check("ack_err", 64'(err), 64'(exp_err));
            check("ack_cycle", 64'(cyc), 64'(exp_ack));
            check("grant_id", 64'(grant_id), 64'(winner));
            check("busy_in_xfer", 64'(busy), 1);
            check("addr_before_ack", 64'(prev_addr), 64'(legal));
            check("n_writes", 64'(wr_q.size()), 64'(exp_w.size()));
            for (int k = 0; k < exp_w.size() && k < wr_q.size(); k++) begin
                check("wr_cycle", 64'(wr_q[k].c), 64'(exp_w[k].c));
                check("wr_addr", 64'(wr_q[k].a), 64'(exp_w[k].a));
                check("wr_data", 64'(wr_q[k].d), 64'(exp_w[k].d));
            end
            wr_q.delete();
            req          = req & ~ack;
            pend[winner] = 1'b0;
            ptr_m        = (winner + 1) % N;
            @(negedge clk);
            check("ack_single_pulse", 64'(ack), 0);
            check("idle_busy", 64'(busy), 0);
            check("idle_addr", 64'(tx.tx_addr), 0);
            c0 = cyc;
        end
    endtask

    task automatic set_all(input logic [5:0] l, input logic [2:0] f);
        for (int i = 0; i < N; i++) begin
            f_len[i]  = l;
            f_freq[i] = f;
            f_data[i] = $urandom;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] s;
        int sel;
        rst = 1'b1;
        req = '0;
        set_all(6'd16, 3'd0);
        pack_fields();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Contention: 0,1,3 then 3 and 0 again.
        set_all(6'd24, 3'd5);
        stub_delay = 2; stub_len = 3;
        run_burst(4'b1011);
        run_burst(4'b1001);

        // Single request with the reference words 0x190 / 0xA5A5.
        f_data[2] = 32'h1234A5A5; f_len[2] = 6'd16; f_freq[2] = 3'd3;
        stub_delay = 2; stub_len = 4;
        run_burst(4'b0100);

        // Illegal lengths (odd, above 32) and the small boundary cases.
        f_len[1] = 6'd7;  run_burst(4'b0010);
        f_len[1] = 6'd34; run_burst(4'b0010);
        f_len[1] = 6'd6;  run_burst(4'b0010);
        f_len[0] = 6'd8;  f_len[3] = 6'd32; run_burst(4'b1001);

        // Fast transmitter: busy never seen.
        stub_delay = 1000; stub_len = 1;
        f_len[3] = 6'd20;
        run_burst(4'b1000);

        // Reset in WAIT_DONE with the pointer moved away from 0.
        stub_delay = 2; stub_len = 3;
        f_len[1] = 6'd12;
        run_burst(4'b0010);
        stub_len = 1000;
        pack_fields();
        req = 4'b0100;
        repeat (8) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 1);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        wr_q.delete();
        stub_len = 3;
        @(negedge clk);
        set_all(6'd16, 3'd2);
        run_burst(4'b1001);

`ifdef SL_SCHED_TIMEOUT_EN
        stub_delay = 2; stub_len = 1000000;
        f_len[2] = 6'd16; f_freq[2] = 3'd6;
        run_burst(4'b0100);
        stub_len = 3;
`endif

        for (int b = 0; b < 40; b++) begin
            s = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                sel       = int'($urandom_range(0, 3));
                f_len[i]  = (sel == 0) ? 6'($urandom_range(0, 63)) : 6'(2 * $urandom_range(4, 16));
                f_freq[i] = 3'($urandom_range(0, 7));
                f_data[i] = $urandom;
            end
            stub_delay = longint'($urandom_range(1, SW + 2));
            stub_len   = longint'($urandom_range(1, 6));
            run_burst(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
